// File: rtl/gelato_inst_buffer_if.sv
// Fetch-side and decode-side handshake bundle of the per-warp instruction buffer.
// Both sides use valid/ready: a transfer happens on a rising edge where the
// sender's valid and the receiver's ready are both high. The sender holds its
// payload steady for that cycle. Ready may depend combinationally on valid.
interface gelato_inst_buffer_if #(
  parameter int PC_WIDTH    = 32,
  parameter int INST_WIDTH  = 32,
  parameter int SPLIT_WIDTH = 4,
  parameter int WARP_WIDTH  = 2
);
  // fetch -> buffer
  logic                   in_valid;
  logic                   in_ready;
  logic [PC_WIDTH-1:0]    in_pc;
  logic [INST_WIDTH-1:0]  in_inst;
  logic [WARP_WIDTH-1:0]  in_warp;
  logic [SPLIT_WIDTH-1:0] in_split;
  // buffer -> decode
  logic                   out_valid;
  logic                   out_ready;
  logic [PC_WIDTH-1:0]    out_pc;
  logic [INST_WIDTH-1:0]  out_inst;
  logic [WARP_WIDTH-1:0]  out_warp;
  logic [SPLIT_WIDTH-1:0] out_split;

  // The buffer side.
  modport slave (
    input  in_valid, in_pc, in_inst, in_warp, in_split, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_warp, out_split
  );

  // The fetch/decode side.
  modport master (
    output in_valid, in_pc, in_inst, in_warp, in_split, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_warp, out_split
  );
endinterface

// File: rtl/gelato_inst_buffer.sv
// Per-warp instruction buffer: one small FIFO per warp, filled by fetch and
// drained one entry per cycle to decode by round-robin over non-empty warps.
// Flush of a single warp empties its FIFO and masks it from that cycle's pick.
module gelato_inst_buffer #(
  parameter int NUM_WARPS   = 4,
  parameter int DEPTH       = 4,
  parameter int PC_WIDTH    = 32,
  parameter int INST_WIDTH  = 32,
  parameter int SPLIT_WIDTH = 4,
  parameter int WARP_WIDTH  = $clog2(NUM_WARPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  gelato_inst_buffer_if.slave   bus,
  input  logic                  flush_valid,
  input  logic [WARP_WIDTH-1:0] flush_warp,
  output logic [NUM_WARPS-1:0]  warp_full,
  output logic [NUM_WARPS-1:0]  warp_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Payload storage; contents are only meaningful below the count, so no reset.
  logic [PC_WIDTH-1:0]    pc_mem    [NUM_WARPS][DEPTH];
  logic [INST_WIDTH-1:0]  inst_mem  [NUM_WARPS][DEPTH];
  logic [SPLIT_WIDTH-1:0] split_mem [NUM_WARPS][DEPTH];

  logic [PTR_W-1:0]      rd_ptr_q [NUM_WARPS];
  logic [PTR_W-1:0]      rd_ptr_d [NUM_WARPS];
  logic [PTR_W-1:0]      wr_ptr_q [NUM_WARPS];
  logic [PTR_W-1:0]      wr_ptr_d [NUM_WARPS];
  logic [CNT_W-1:0]      cnt_q    [NUM_WARPS];
  logic [CNT_W-1:0]      cnt_d    [NUM_WARPS];
  logic [WARP_WIDTH-1:0] rr_ptr_q;
  logic [WARP_WIDTH-1:0] rr_ptr_d;

  logic                  flush_act;
  logic                  sel_found;
  logic [WARP_WIDTH-1:0] sel;
  logic [WARP_WIDTH-1:0] idx;
  logic                  push;
  logic                  pop;

  // Occupancy flags straight from the registered counts.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_full[w]  = (cnt_q[w] == CNT_W'(DEPTH));
      warp_empty[w] = (cnt_q[w] == '0);
    end
  end

  // Round-robin pick: first non-empty, non-flushed warp at or after rr_ptr.
  always_comb begin
    flush_act = rdy & flush_valid;
    sel_found = 1'b0;
    sel       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      idx = rr_ptr_q + WARP_WIDTH'(i);
      if (!sel_found && !warp_empty[idx] && !(flush_act && (flush_warp == idx))) begin
        sel_found = 1'b1;
        sel       = idx;
      end
    end
  end

  // Handshake outputs; rst_n gates in_ready so it drops with reset, not an edge.
  always_comb begin
    bus.in_ready  = rst_n & rdy & ~warp_full[bus.in_warp];
    bus.out_valid = rdy & sel_found;
    bus.out_pc    = '0;
    bus.out_inst  = '0;
    bus.out_split = '0;
    bus.out_warp  = '0;
    if (bus.out_valid) begin
      bus.out_pc    = pc_mem[sel][rd_ptr_q[sel]];
      bus.out_inst  = inst_mem[sel][rd_ptr_q[sel]];
      bus.out_split = split_mem[sel][rd_ptr_q[sel]];
      bus.out_warp  = sel;
    end
    push = bus.in_valid & bus.in_ready;
    pop  = bus.out_valid & bus.out_ready;
  end

  // Next pointers/counts; flush overrides any same-cycle push to that warp.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      rd_ptr_d[w] = rd_ptr_q[w];
      wr_ptr_d[w] = wr_ptr_q[w];
      cnt_d[w]    = cnt_q[w];
      if (flush_act && (flush_warp == WARP_WIDTH'(w))) begin
        rd_ptr_d[w] = '0;
        wr_ptr_d[w] = '0;
        cnt_d[w]    = '0;
      end else begin
        if (push && (bus.in_warp == WARP_WIDTH'(w))) begin
          wr_ptr_d[w] = wr_ptr_q[w] + 1'b1;
        end
        if (pop && (sel == WARP_WIDTH'(w))) begin
          rd_ptr_d[w] = rd_ptr_q[w] + 1'b1;
        end
        cnt_d[w] = cnt_q[w]
                 + CNT_W'(push && (bus.in_warp == WARP_WIDTH'(w)))
                 - CNT_W'(pop && (sel == WARP_WIDTH'(w)));
      end
    end
    rr_ptr_d = pop ? (sel + 1'b1) : rr_ptr_q;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_ptr_q[w] <= '0;
        wr_ptr_q[w] <= '0;
        cnt_q[w]    <= '0;
      end
      rr_ptr_q <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rd_ptr_q[w] <= rd_ptr_d[w];
        wr_ptr_q[w] <= wr_ptr_d[w];
        cnt_q[w]    <= cnt_d[w];
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Payload write on every accepted push (a flushed push lands but is never read).
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[bus.in_warp][wr_ptr_q[bus.in_warp]]    <= bus.in_pc;
      inst_mem[bus.in_warp][wr_ptr_q[bus.in_warp]]  <= bus.in_inst;
      split_mem[bus.in_warp][wr_ptr_q[bus.in_warp]] <= bus.in_split;
    end
  end
endmodule

// File: tb/tb_gelato_inst_buffer.sv
// Bench for gelato_inst_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-per-warp reference model.
module tb_gelato_inst_buffer;
  localparam int NW = 4;
  localparam int DP = 4;
  localparam int EW = 32 + 32 + 4;

  logic          clk;
  logic          rst_n;
  logic          rdy;
  logic          flush_valid;
  logic [1:0]    flush_warp;
  logic [NW-1:0] warp_full;
  logic [NW-1:0] warp_empty;

  gelato_inst_buffer_if #(.PC_WIDTH(32), .INST_WIDTH(32), .SPLIT_WIDTH(4), .WARP_WIDTH(2)) bus ();

  gelato_inst_buffer #(.NUM_WARPS(NW), .DEPTH(DP), .PC_WIDTH(32), .INST_WIDTH(32),
                       .SPLIT_WIDTH(4), .WARP_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus),
    .flush_valid(flush_valid), .flush_warp(flush_warp),
    .warp_full(warp_full), .warp_empty(warp_empty)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one queue of {pc,inst,split} per warp, plus rr pointer
  logic [EW-1:0] exp_q [NW][$];
  int            rr;
  int            n_vec;
  int            n_err;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [1:0] w, input logic [31:0] pc,
                       input logic [31:0] inst, input logic [3:0] sp, input logic ordy,
                       input logic fv, input logic [1:0] fw);
    rdy = r; bus.in_valid = iv; bus.in_warp = w; bus.in_pc = pc; bus.in_inst = inst;
    bus.in_split = sp; bus.out_ready = ordy; flush_valid = fv; flush_warp = fw;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 4'h0, ordy, 1'b0, 2'd0);
  endtask

  // One clock: check outputs at the falling edge, update the model after the rising edge.
  task automatic cycle();
    bit            fl, ok_push, do_pop, exp_valid, exp_ready;
    int            sel;
    logic [EW-1:0] head;
    logic [NW-1:0] ef, ee;
    @(negedge clk);
    fl  = rdy && flush_valid;
    sel = -1;
    for (int i = 0; i < NW; i++) begin
      int w;
      w = (rr + i) % NW;
      if (sel < 0 && exp_q[w].size() > 0 && !(fl && int'(flush_warp) == w)) sel = w;
    end
    exp_valid = rdy && (sel >= 0);
    exp_ready = rdy && (exp_q[bus.in_warp].size() < DP);
    for (int w = 0; w < NW; w++) begin
      ef[w] = (exp_q[w].size() == DP);
      ee[w] = (exp_q[w].size() == 0);
    end
    chk("in_ready", bus.in_ready, exp_ready);
    chk("out_valid", bus.out_valid, exp_valid);
    chk("warp_full", warp_full, ef);
    chk("warp_empty", warp_empty, ee);
    if (exp_valid) begin
      head = exp_q[sel][0];
      chk("out_warp", bus.out_warp, sel);
      chk("out_pc", bus.out_pc, head[67:36]);
      chk("out_inst", bus.out_inst, head[35:4]);
      chk("out_split", bus.out_split, head[3:0]);
    end
    ok_push = bus.in_valid && exp_ready;
    do_pop  = exp_valid && bus.out_ready;
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(exp_q[sel].pop_front());
      rr = (sel + 1) % NW;
    end
    if (ok_push && !(fl && flush_warp == bus.in_warp))
      exp_q[bus.in_warp].push_back({bus.in_pc, bus.in_inst, bus.in_split});
    if (fl) exp_q[flush_warp].delete();
  endtask

  task automatic push1(input logic [1:0] w, input logic [31:0] pc, input logic ordy);
    drive(1'b1, 1'b1, w, pc, $urandom, 4'($urandom_range(0, 15)), ordy, 1'b0, 2'd0);
    cycle();
  endtask

  task automatic drain();
    idle(1'b1);
    for (int i = 0; i < 20; i++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_warp_full"}, warp_full, 4'b0000);
    chk({tag, "_warp_empty"}, warp_empty, 4'b1111);
    chk({tag, "_out_pc"}, bus.out_pc, 32'h0);
    chk({tag, "_out_warp"}, bus.out_warp, 2'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; rr = 0;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'd1, 32'h44, 32'h55, 4'h2, 1'b1, 1'b0, 2'd0);
    #2;
    check_reset_outputs("reset");
    #10;
    rst_n = 1'b1;
    idle(1'b0);
    @(posedge clk); #1;

    // single push to warp 2, visible next cycle, then consumed
    drive(1'b1, 1'b1, 2'd2, 32'h100, 32'hDEADBEEF, 4'h1, 1'b1, 1'b0, 2'd0);
    cycle();
    idle(1'b1);
    cycle();
    cycle();

    // fill warp 0, attempt a fifth push, drain; three rounds to wrap pointers
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) push1(2'd0, 32'h1000 + 32'(r * 16 + k), 1'b0);
      drain();
    end

    // one entry in warps 0,1,3 then drain; refill 3 and 1
    push1(2'd0, 32'h200, 1'b0);
    push1(2'd1, 32'h201, 1'b0);
    push1(2'd3, 32'h203, 1'b0);
    drain();
    push1(2'd3, 32'h303, 1'b0);
    push1(2'd1, 32'h301, 1'b0);
    drain();

    // warp 1 full, push and pop warp 1 together: push refused
    for (int k = 0; k < 4; k++) push1(2'd1, 32'h400 + 32'(k), 1'b0);
    drive(1'b1, 1'b1, 2'd1, 32'h4FF, 32'h1, 4'h0, 1'b1, 1'b0, 2'd0);
    cycle();
    idle(1'b0);
    cycle();
    chk("w1_not_full", warp_full[1], 1'b0);
    drain();

    // flush warp 2 while pushing to it; warp 0 stays eligible
    for (int k = 0; k < 3; k++) push1(2'd2, 32'h500 + 32'(k), 1'b0);
    push1(2'd0, 32'h600, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 32'h5FF, 32'h2, 4'h3, 1'b1, 1'b1, 2'd2);
    cycle();
    drain();

    // rdy low freezes everything
    push1(2'd3, 32'h700, 1'b0);
    drive(1'b0, 1'b1, 2'd3, 32'h701, 32'h3, 4'h0, 1'b1, 1'b1, 2'd3);
    cycle();
    cycle();
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
            $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)));
      cycle();
    end

    // asynchronous reset with warps populated
    for (int k = 0; k < 4; k++) push1(2'd0, 32'h800 + 32'(k), 1'b0);
    push1(2'd2, 32'h900, 1'b0);
    idle(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    for (int w = 0; w < NW; w++) exp_q[w].delete();
    rr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push1(2'd3, 32'hA00, 1'b1);
    idle(1'b1);
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/gelato_inst_buffer.md
# gelato_inst_buffer

Per-warp instruction buffer sitting directly downstream of the instruction fetch stage. It accepts raw instruction words tagged with PC, warp number and split-table number, queues them in one small FIFO per warp, and issues them one per cycle to the decode stage through round-robin arbitration across non-empty warps. It exports per-warp full flags to the fetch scheduler so that no warp is fetched into a full queue, and supports per-warp flush on control-flow redirect.

## Interface
Parameters:
- NUM_WARPS, 4: number of warps; power of two, ≥2.
- DEPTH, 4: entries per warp FIFO; power of two, ≥2.
- PC_WIDTH, 32: PC width.
- INST_WIDTH, 32: instruction word width.
- SPLIT_WIDTH, 4: split-table number width.
- WARP_WIDTH, $clog2(NUM_WARPS): warp number width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- rdy  in  1  global enable; when low, no state changes, in_ready=0, out_valid=0.
- in_valid  in  1  fetched instruction present.
- in_ready  out  1  buffer accepts in this cycle.
- in_pc  in  PC_WIDTH  instruction PC.
- in_inst  in  INST_WIDTH  raw instruction word.
- in_warp  in  WARP_WIDTH  owning warp.
- in_split  in  SPLIT_WIDTH  split-table number.
- out_valid  out  1  an entry is offered to decode.
- out_ready  in  1  decode consumes this cycle.
- out_pc / out_inst / out_warp / out_split  out  as above  head entry of the selected warp.
- flush_valid  in  1  discard all entries of flush_warp.
- flush_warp  in  WARP_WIDTH  warp to flush.
- warp_full  out  NUM_WARPS  bit w set when warp w's FIFO holds DEPTH entries.
- warp_empty  out  NUM_WARPS  bit w set when warp w's FIFO is empty.

## Operation
- Storage: per warp, DEPTH entries of {pc, inst, split}, read pointer, write pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH)+1 bits, 0..DEPTH).
- Push: occurs when rdy & in_valid & in_ready. in_ready = rdy & !warp_full[in_warp]. Entry written at write pointer of in_warp; pointer and count increment.
- A push to a full warp is refused even if that warp pops in the same cycle (no bypass).
- Arbitration: registered rr_ptr (WARP_WIDTH bits). Selected warp = first warp w with a non-empty FIFO and not being flushed this cycle, scanning from rr_ptr upward, wrapping. out_valid = rdy & a selected warp exists. out_* driven combinationally from that warp's head entry; out_warp = selected index.
- Pop: out_valid & out_ready. Selected warp's read pointer increments, count decrements, rr_ptr <= selected+1 (mod NUM_WARPS). rr_ptr unchanged when no pop.
- Simultaneous push and pop on the same non-full warp: count unchanged, both pointers advance.
- Flush: when rdy & flush_valid, warp flush_warp's pointers and count reset to 0. Flush beats a same-cycle push to that warp (in_ready still reflects the pre-flush full flag; the accepted entry is discarded). The flushed warp is masked from arbitration that cycle, so it is never popped concurrently.
- Reset (asynchronous, mid-operation included): all counts, pointers, rr_ptr cleared; outputs immediately out_valid=0, in_ready=0, warp_full=0, warp_empty=all ones, out_* = 0 while out_valid=0 is don't-care but driven 0 on reset. Storage array is not reset.

## Timing
- Push at edge N visible at out_* in cycle N+1 (minimum latency 1 cycle; no same-cycle in→out bypass).
- warp_full/warp_empty are registered-state functions; update one cycle after the push/pop/flush edge.
- Throughput: one push and one pop per cycle sustained.
- Decode may hold out_ready low indefinitely; the offered entry stays stable unless a flush or a higher-priority arbitration change occurs (arbitration changes only with rr_ptr or FIFO occupancy).

## Test plan
- Reset, push warp 2 pc=0x100 inst=0xDEADBEEF split=1 with out_ready=1 -> next cycle out_valid=1, out_warp=2, out_pc=0x100, out_inst=0xDEADBEEF; following cycle warp_empty=4'b1111.
- Push 4 entries to warp 0 with out_ready=0 -> warp_full[0]=1, 5th push sees in_ready=0; pops return entries in push order; pointers wrap correctly over 3 fill/drain rounds.
- One entry each in warps 0,1,3, out_ready=1 -> pops ordered warps 0,1,3, then rr_ptr=0; refill warp 3 and 1 -> order 1 then 3.
- Warp 1 full, same-cycle push and pop on warp 1 -> push refused (in_ready=0), count 3 afterwards.
- Warp 2 holding 3 entries, flush_valid with flush_warp=2 concurrent with push to warp 2 -> out_valid not for warp 2 that cycle, warp_empty[2]=1 next cycle, pushed entry never appears.
- rst_n asserted mid-stream with warps non-empty -> out_valid and warp_full drop immediately without a clock edge; after release, all warps empty, first push issues normally.
